fetch_queue: RTL and testbench

//  Instruction buffer between the instruction cache and register_decode.

---
 rtl/fetch_queue_pkg.sv | 17 +
 rtl/fetch_queue_if.sv | 31 +++
 rtl/fetch_queue.sv | 97 +++++++++
 tb/tb_fetch_queue.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared fetch-path types: the queued fetch entry and the decode bubble encoding.
package fetch_queue_pkg;

  localparam int unsigned FQ_DEPTH  = 4;
  localparam int unsigned FQ_INSTSZ = 32;
  localparam int unsigned FQ_WORDSZ = 64;

  // addi x0, x0, 0 -- what decode inserts when it has nothing to issue
  localparam logic [FQ_INSTSZ-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [FQ_WORDSZ-1:0] pc;
    logic [FQ_INSTSZ-1:0] instr;
    logic                 misaligned;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Icache-to-queue push channel and queue-to-decode pop channel.
interface fetch_queue_if
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = FQ_DEPTH,
  parameter int unsigned INSTSZ = FQ_INSTSZ,
  parameter int unsigned WORDSZ = FQ_WORDSZ
) ();

  logic                     in_valid;
  logic [WORDSZ-1:0]        in_pc;
  logic [INSTSZ-1:0]        in_instr;
  logic                     in_ready;
  logic                     out_valid;
  logic [WORDSZ-1:0]        out_pc;
  logic [INSTSZ-1:0]        out_instr;
  logic                     out_misaligned;
  logic                     out_ready;
  logic [$clog2(DEPTH):0]   occupancy;

  modport master (
    output in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, out_misaligned, occupancy
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr, out_misaligned, occupancy
  );

endinterface

// File: rtl/fetch_queue.sv
// In-order instruction buffer between icache and decode; redirect flush empties it.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = FQ_DEPTH,
  parameter int unsigned INSTSZ = FQ_INSTSZ,
  parameter int unsigned WORDSZ = FQ_WORDSZ
) (
  input logic          clk,
  input logic          reset,
  input logic          flush,
  fetch_queue_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  fq_entry_t             mem_q [DEPTH];
  logic [PtrW-1:0]       head_q, head_d;
  logic [PtrW-1:0]       tail_q, tail_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  push, pop;
  fq_entry_t             in_entry;
  fq_entry_t             head_entry;
  logic [WORDSZ-1:0]     head_pc;
  logic [INSTSZ-1:0]     head_instr;

  // Ready depends on registered count only, so a full queue never admits a push
  // in the same cycle decode pops.
  assign bus.in_ready  = (count_q != CntW'(DEPTH));
  assign bus.out_valid = (count_q != '0);
  assign push          = bus.in_valid & bus.in_ready;
  assign pop           = bus.out_valid & bus.out_ready;

  assign in_entry.pc         = bus.in_pc;
  assign in_entry.instr      = bus.in_instr;
  assign in_entry.misaligned = (bus.in_pc[1:0] != 2'b00);

  assign head_entry = mem_q[head_q];
  assign head_pc    = head_entry.pc;
  assign head_instr = head_entry.instr;

  assign bus.out_pc         = bus.out_valid ? head_pc : '0;
  assign bus.out_instr      = bus.out_valid ? head_instr : '0;
  assign bus.out_misaligned = bus.out_valid & head_entry.misaligned;
  assign bus.occupancy      = count_q;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PtrW'(1);
      if (pop)  head_d = head_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // A push discarded by flush must not leave a stale write behind the new tail.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push && !flush) begin
      mem_q[tail_q] <= in_entry;
    end
  end

  a_count_bound : assert property (@(posedge clk) disable iff (!reset)
    count_q <= CntW'(DEPTH));
  a_no_push_full : assert property (@(posedge clk) disable iff (!reset)
    !(push && !bus.in_ready));
  a_ptr_count : assert property (@(posedge clk) disable iff (!reset)
    PtrW'(tail_q - head_q) == count_q[PtrW-1:0]);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, ordering, full/pop, streaming, flush, misalignment.
module tb_fetch_queue;

  logic clk;
  logic reset;
  logic flush;
  int   tests;
  int   fails;

  fetch_queue_if #(.DEPTH(4), .INSTSZ(32), .WORDSZ(64)) bus ();

  fetch_queue #(.DEPTH(4), .INSTSZ(32), .WORDSZ(64)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                       input logic rdy);
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_instr  = ins;
    bus.out_ready = rdy;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b1, 64'hdead_0000, 32'h1234_5678, 1'b1);
    repeat (3) tick();
    drive(1'b0, 64'h0, 32'h0, 1'b0);
    reset = 1'b1;
    tick();
    tests++; if (bus.out_valid !== 1'b0) begin fails++;
      $display("FAIL reset_out_valid: got %0b want 0", bus.out_valid); end
    tests++; if (bus.occupancy !== 3'd0) begin fails++;
      $display("FAIL reset_occupancy: got %0d want 0", bus.occupancy); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++;
      $display("FAIL reset_in_ready: got %0b want 1", bus.in_ready); end
    tests++; if (bus.out_pc !== 64'h0 || bus.out_instr !== 32'h0 || bus.out_misaligned !== 1'b0)
      begin fails++; $display("FAIL reset_outputs: got pc %h instr %h mis %0b want 0",
        bus.out_pc, bus.out_instr, bus.out_misaligned); end
  endtask

  task automatic test_order();
    logic [63:0] pc;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'h1000 + 64'(4 * i), 32'h13 + 32'(i), 1'b0);
      tick();
      if (i == 0) begin
        tests++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h1000) begin fails++;
          $display("FAIL order_latency: got valid %0b pc %h want 1 1000",
            bus.out_valid, bus.out_pc); end
      end
    end
    tests++; if (bus.occupancy !== 3'd4) begin fails++;
      $display("FAIL order_full_occ: got %0d want 4", bus.occupancy); end
    tests++; if (bus.in_ready !== 1'b0) begin fails++;
      $display("FAIL order_full_ready: got %0b want 0", bus.in_ready); end
    drive(1'b0, 64'h0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      pc = 64'h1000 + 64'(4 * i);
      tests++; if (bus.out_valid !== 1'b1 || bus.out_pc !== pc || bus.out_instr !== 32'h13 + 32'(i))
        begin fails++; $display("FAIL order_deq%0d: got pc %h instr %h want %h %h", i,
          bus.out_pc, bus.out_instr, pc, 32'h13 + 32'(i)); end
      tick();
    end
    tests++; if (bus.out_valid !== 1'b0 || bus.occupancy !== 3'd0) begin fails++;
      $display("FAIL order_drained: got valid %0b occ %0d want 0 0",
        bus.out_valid, bus.occupancy); end
  endtask

  task automatic test_full_pop();
    logic [63:0] pc;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'h3000 + 64'(4 * i), 32'h100 + 32'(i), 1'b0);
      tick();
    end
    drive(1'b1, 64'h3010, 32'h104, 1'b1);
    tests++; if (bus.in_ready !== 1'b0) begin fails++;
      $display("FAIL full_ready: got %0b want 0", bus.in_ready); end
    tick();
    tests++; if (bus.occupancy !== 3'd3 || bus.out_pc !== 64'h3004) begin fails++;
      $display("FAIL full_pop_only: got occ %0d pc %h want 3 3004", bus.occupancy, bus.out_pc); end
    tests++; if (bus.in_ready !== 1'b1) begin fails++;
      $display("FAIL full_ready_next: got %0b want 1", bus.in_ready); end
    tick();
    tests++; if (bus.occupancy !== 3'd3 || bus.out_pc !== 64'h3008) begin fails++;
      $display("FAIL full_push_pop: got occ %0d pc %h want 3 3008", bus.occupancy, bus.out_pc); end
    drive(1'b0, 64'h0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      pc = 64'h3008 + 64'(4 * i);
      tests++; if (bus.out_valid !== 1'b1 || bus.out_pc !== pc) begin fails++;
        $display("FAIL full_drain%0d: got pc %h want %h", i, bus.out_pc, pc); end
      tick();
    end
    tests++; if (bus.occupancy !== 3'd0) begin fails++;
      $display("FAIL full_drained: got %0d want 0", bus.occupancy); end
  endtask

  task automatic test_streaming();
    logic [63:0] pc;
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 64'h4000 + 64'(4 * k), 32'h200 + 32'(k), 1'b1);
      if (k > 0) begin
        pc = 64'h4000 + 64'(4 * (k - 1));
        tests++; if (bus.out_valid !== 1'b1 || bus.out_pc !== pc) begin fails++;
          $display("FAIL stream_head%0d: got pc %h want %h", k, bus.out_pc, pc); end
      end
      tick();
      tests++; if (bus.occupancy !== 3'd1) begin fails++;
        $display("FAIL stream_occ%0d: got %0d want 1", k, bus.occupancy); end
    end
    drive(1'b0, 64'h0, 32'h0, 1'b1);
    tests++; if (bus.out_pc !== 64'h404C || bus.out_instr !== 32'h213) begin fails++;
      $display("FAIL stream_last: got pc %h instr %h want 404c 213", bus.out_pc, bus.out_instr); end
    tick();
    tests++; if (bus.occupancy !== 3'd0 || bus.out_valid !== 1'b0) begin fails++;
      $display("FAIL stream_empty: got occ %0d valid %0b want 0 0",
        bus.occupancy, bus.out_valid); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'h5000 + 64'(4 * i), 32'h300 + 32'(i), 1'b0);
      tick();
    end
    drive(1'b1, 64'h5100, 32'h3ff, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 64'h0, 32'h0, 1'b0);
    tests++; if (bus.occupancy !== 3'd0 || bus.out_valid !== 1'b0 || bus.out_pc !== 64'h0)
      begin fails++; $display("FAIL flush_empty: got occ %0d valid %0b pc %h want 0 0 0",
        bus.occupancy, bus.out_valid, bus.out_pc); end
    drive(1'b1, 64'h2000, 32'h400, 1'b0);
    tick();
    drive(1'b0, 64'h0, 32'h0, 1'b1);
    tests++; if (bus.occupancy !== 3'd1 || bus.out_pc !== 64'h2000 || bus.out_instr !== 32'h400)
      begin fails++; $display("FAIL flush_next_push: got occ %0d pc %h instr %h want 1 2000 400",
        bus.occupancy, bus.out_pc, bus.out_instr); end
    tick();
    tests++; if (bus.occupancy !== 3'd0) begin fails++;
      $display("FAIL flush_drain: got %0d want 0", bus.occupancy); end
  endtask

  task automatic test_misaligned();
    drive(1'b1, 64'h1002, 32'h500, 1'b0);
    tick();
    tests++; if (bus.out_misaligned !== 1'b1 || bus.out_pc !== 64'h1002) begin fails++;
      $display("FAIL misaligned_set: got mis %0b pc %h want 1 1002",
        bus.out_misaligned, bus.out_pc); end
    drive(1'b1, 64'h1004, 32'h501, 1'b0);
    tick();
    drive(1'b0, 64'h0, 32'h0, 1'b1);
    tick();
    tests++; if (bus.out_misaligned !== 1'b0 || bus.out_pc !== 64'h1004) begin fails++;
      $display("FAIL misaligned_clear: got mis %0b pc %h want 0 1004",
        bus.out_misaligned, bus.out_pc); end
    tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 64'h6000 + 64'(4 * i), 32'h600 + 32'(i), 1'b0);
      tick();
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    drive(1'b0, 64'h0, 32'h0, 1'b0);
    tests++; if (bus.occupancy !== 3'd0 || bus.out_valid !== 1'b0 || bus.out_pc !== 64'h0)
      begin fails++; $display("FAIL reset_mid: got occ %0d valid %0b pc %h want 0 0 0",
        bus.occupancy, bus.out_valid, bus.out_pc); end
    tick();
    tests++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin fails++;
      $display("FAIL reset_mid_after: got ready %0b valid %0b want 1 0",
        bus.in_ready, bus.out_valid); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    flush = 1'b0;
    drive(1'b0, 64'h0, 32'h0, 1'b0);
    test_reset();
    test_order();
    test_full_pop();
    test_streaming();
    test_flush();
    test_misaligned();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
